// File: rtl/constraint_sampler_if.sv
// Stream, checker and control signals between the constraint sampler and its environment.
// The slave modport is the sampler's view; the master modport is the driver/consumer view.
interface constraint_sampler_if #(
    parameter int VEC_W = 185
);
    logic             start;
    logic [31:0]      seed;
    logic [15:0]      num_samples;
    logic [VEC_W-1:0] cand_vec;
    logic             chk_result;
    logic             out_valid;
    logic             out_ready;
    logic [VEC_W-1:0] out_data;
    logic             busy;
    logic             done;
    logic             fail;
    logic [15:0]      sample_cnt;
    logic [15:0]      tries_total;

    modport master (
        output start, seed, num_samples, chk_result, out_ready,
        input  cand_vec, out_valid, out_data, busy, done, fail, sample_cnt, tries_total
    );

    modport slave (
        input  start, seed, num_samples, chk_result, out_ready,
        output cand_vec, out_valid, out_data, busy, done, fail, sample_cnt, tries_total
    );
endinterface

// File: rtl/constraint_sampler_ctrl.sv
// Rejection-sampling scheduler: builds xorshift32 candidates, retries on checker reject,
// and streams accepted vectors out with sample/attempt counting and a retry budget.
module constraint_sampler_ctrl #(
    parameter int VEC_W     = 185,
    parameter int CHK_LAT   = 0,
    parameter int MAX_TRIES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    constraint_sampler_if.slave  bus
);
    localparam int NW  = (VEC_W + 31) / 32;
    localparam int WCW = (NW > 1) ? $clog2(NW) : 1;
    localparam int LCW = (CHK_LAT > 0) ? $clog2(CHK_LAT + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_GEN, S_CHECK, S_EMIT, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [31:0]      prng, prng_step;
    logic [VEC_W-1:0] cand_q, cand_next;
    logic [WCW-1:0]   word_cnt;
    logic [LCW-1:0]   lat_cnt;
    logic [15:0]      tries, tries_total_q, sample_cnt_q, num_q;
    logic             fail_q;
    logic             gen_last, chk_ready, tries_out, run_last;

    always_comb begin
        prng_step = prng ^ (prng << 13);
        prng_step = prng_step ^ (prng_step >> 17);
        prng_step = prng_step ^ (prng_step << 5);
    end

    // Newest word always lands in the low 32 bits; older words shift toward the MSB.
    generate
        if (VEC_W > 32) begin : g_wide
            assign cand_next = {cand_q[VEC_W-33:0], prng_step};
        end else begin : g_narrow
            assign cand_next = prng_step[VEC_W-1:0];
        end
    endgenerate

    assign gen_last  = (word_cnt == WCW'(NW - 1));
    assign chk_ready = (lat_cnt == LCW'(CHK_LAT));
    assign tries_out = (tries == 16'(MAX_TRIES));
    assign run_last  = (sample_cnt_q == num_q - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = (bus.num_samples == 16'd0) ? S_DONE : S_GEN;
            S_GEN:   if (gen_last) state_nxt = S_CHECK;
            S_CHECK: begin
                if (chk_ready) begin
                    if (bus.chk_result)  state_nxt = S_EMIT;
                    else if (tries_out)  state_nxt = S_DONE;
                    else                 state_nxt = S_GEN;
                end
            end
            S_EMIT:  if (bus.out_ready) state_nxt = run_last ? S_DONE : S_GEN;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prng          <= 32'd0;
            cand_q        <= '0;
            word_cnt      <= '0;
            lat_cnt       <= '0;
            tries         <= 16'd0;
            tries_total_q <= 16'd0;
            sample_cnt_q  <= 16'd0;
            num_q         <= 16'd0;
            fail_q        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        // A zero seed would lock xorshift at zero forever.
                        prng          <= (bus.seed == 32'd0) ? 32'd1 : bus.seed;
                        num_q         <= bus.num_samples;
                        sample_cnt_q  <= 16'd0;
                        tries_total_q <= 16'd0;
                        tries         <= 16'd0;
                        fail_q        <= 1'b0;
                        word_cnt      <= '0;
                        lat_cnt       <= '0;
                    end
                end
                S_GEN: begin
                    prng   <= prng_step;
                    cand_q <= cand_next;
                    if (gen_last) begin
                        word_cnt <= '0;
                        lat_cnt  <= '0;
                        tries    <= tries + 16'd1;
                        if (tries_total_q != 16'hFFFF) tries_total_q <= tries_total_q + 16'd1;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (!chk_ready)                             lat_cnt <= lat_cnt + 1'b1;
                    else if (!bus.chk_result && tries_out)      fail_q  <= 1'b1;
                end
                S_EMIT: begin
                    if (bus.out_ready) begin
                        sample_cnt_q <= sample_cnt_q + 16'd1;
                        tries        <= 16'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stream and status outputs decode registered state only, so ready never feeds valid.
    assign bus.cand_vec    = cand_q;
    assign bus.out_data    = cand_q;
    assign bus.out_valid   = (state == S_EMIT);
    assign bus.busy        = (state != S_IDLE);
    assign bus.done        = (state == S_DONE);
    assign bus.fail        = fail_q;
    assign bus.sample_cnt  = sample_cnt_q;
    assign bus.tries_total = tries_total_q;
endmodule

// File: doc/constraint_sampler_ctrl.md
Name: constraint_sampler_ctrl

Overview:
- Rejection-sampling scheduler for one generated constraint-checker datapath.
- The checker takes a flat concatenation of all random variables as candidate vector `cand_vec`, and returns a 1-bit "all constraints hold" result.
- This block generates pseudo-random candidates, waits for the checker result, retries on reject, and hands accepted vectors out over a valid/ready stream.
- It counts samples and attempts, and aborts a run when one sample exceeds its retry budget.

Parameters:
- VEC_W, 185, candidate vector width (sum of checker input widths).
- CHK_LAT, 0, checker result latency in cycles after `cand_vec` becomes stable (0 = combinational).
- MAX_TRIES, 1024, maximum candidates tried per sample before fail; range 1..65535.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- seed  in  32  PRNG seed, latched on accepted start.
- num_samples  in  16  accepted samples requested, latched on start.
- cand_vec  out  VEC_W  candidate driven to the checker.
- chk_result  in  1  checker verdict for `cand_vec`.
- out_valid  out  1  accepted sample available.
- out_ready  in  1  consumer accepts sample.
- out_data  out  VEC_W  accepted sample; equals `cand_vec` while `out_valid`.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of run.
- fail  out  1  run aborted on retry budget; valid with `done`, held until next accepted start.
- sample_cnt  out  16  samples accepted in current run.
- tries_total  out  16  candidates checked in current run, saturating at 0xFFFF.

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - All outputs 0, including `cand_vec`, `out_data`, `fail` and counters.
  - PRNG register is 0.
- PRNG: xorshift32, one step per cycle in GEN: x^=x<<13; x^=x>>17; x^=x<<5.
  - On start, PRNG loads `seed`; seed 0 is replaced by 32'h1.
  - The first generated word is step(seed).
- NW = ceil(VEC_W/32); 6 at default.
- IDLE:
  - start=1 latches seed and num_samples.
  - Clears sample_cnt, tries_total and fail.
  - If num_samples=0: go to DONE. Otherwise go to GEN.
- GEN (NW cycles): each cycle:
  - Advance the PRNG.
  - `cand_vec <= {cand_vec, word}` truncated to VEC_W bits; the last word ends in bits [31:0].
  - After the NW-th word, go to CHECK. Per-sample try counter increments, and tries_total increments (saturating).
- CHECK:
  - Hold `cand_vec` stable for CHK_LAT cycles, then sample `chk_result` on the next edge. With CHK_LAT=0, sample on the first CHECK edge.
  - On 1: go to EMIT and set `out_valid`.
  - On 0 with per-sample tries < MAX_TRIES: go to GEN. The PRNG continues; it is not reseeded.
  - On 0 with tries = MAX_TRIES: set fail, go to DONE.
- EMIT:
  - `out_valid` held, `out_data`/`cand_vec` frozen until out_ready=1.
  - On the handshake edge: sample_cnt++ and the per-sample try counter is cleared.
  - If sample_cnt+1 = num_samples, go to DONE; else go to GEN.
  - `out_valid` drops on that same edge. There is no combinational path from out_ready to out_valid.
- DONE: `done`=1 for exactly one cycle, then IDLE.
  - busy stays 1 in DONE.
  - sample_cnt, tries_total and fail hold until the next start.
- Busy behaviour: start is ignored while busy. out_ready is ignored outside EMIT.
- Latency: first `out_valid` is visible after the (NW+CHK_LAT+1)-th rising edge following the start edge; 7 edges at default.
- Reset asserted mid-run: immediate return to IDLE. No `done` pulse. Any pending sample is discarded.

Test Plan:
- Stub `chk_result`=1, CHK_LAT=0, seed=0, num_samples=1, out_ready=1:
  - `out_valid` rises 7 edges after start.
  - `out_data[31:0]` equals the 6th xorshift32 output from x=1; the first output is 32'h00042021.
  - `done` pulses 1 cycle after the handshake; tries_total=1, fail=0.
- Checker accepts only when `cand_vec[0]`=1, num_samples=4:
  - Every emitted `out_data[0]`=1; sample_cnt=4.
  - tries_total equals the count of candidates checked, which a reference-model xorshift stream confirms.
- `chk_result` tied 0, MAX_TRIES=5:
  - `done` and fail assert after 5 candidates; tries_total=5, `out_valid` never high.
- num_samples=3, out_ready low for 10 cycles per sample:
  - `out_valid` and `out_data` stay stable throughout the stall; exactly 3 handshakes, no duplicated or dropped samples.
- num_samples=0: `done` one cycle after start, no GEN cycles, tries_total=0. A start pulse while busy leaves the latched num_samples unchanged.
- rst_n low mid-GEN and again mid-EMIT:
  - All outputs 0 immediately, asynchronously; no `done`.
  - A subsequent start with the same seed reproduces the identical sample sequence.
